load_unit: RTL and testbench
============================

# load_unit

Sequential load path between the execute stage and the data-memory port; counterpart to the store helper, which produces address, replicated data and byte mask for stores. Accepts one load per start pulse, computes the effective address and issues a word-aligned read with a request/ready handshake. Waits for the read response, then extracts and sign- or zero-extends the addressed byte, halfword or word. Misaligned and illegal loads are reported without touching memory.

## Interface
- No parameters; data and address widths are fixed at 32 bits.
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle load request; sampled only in IDLE
- rs1_data  in  32  base register value
- Iimm  in  32  sign-extended I-type immediate
- funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; all other codes illegal
- mem_req  out  1  read request to data memory
- mem_addr  out  32  word-aligned read address, {eff_addr[31:2], 2'b00}
- mem_ready  in  1  memory accepts request this cycle when mem_req=1
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data word, little-endian byte lanes
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, result or error valid
- load_data  out  32  extended load result, held until next done
- load_err  out  1  qualifies done; misaligned or illegal funct3

## Operation
- eff_addr = rs1_data + Iimm, modulo 2^32, latched with funct3 on accepted start.
- State IDLE: on start, check the load first.
  - Illegal funct3, LH/LHU with eff_addr[0]=1, or LW with eff_addr[1:0]!=00: go to DONE with the error flag set and load result 0.
  - Otherwise go to REQ.
- State REQ: mem_req=1 with mem_addr stable. Go to WAIT on mem_ready=1; otherwise stay in REQ.
- State WAIT: on mem_rvalid=1, capture the extracted result and go to DONE.
- State DONE: done=1 for exactly one cycle, then IDLE.
- Extraction uses off = eff_addr[1:0].
  - Byte: lane mem_rdata[8*off+7 : 8*off]. LB sign-extends bit 7; LBU zero-extends.
  - Halfword: lanes [31:16] when off[1]=1, else [15:0]. LH sign-extends bit 15; LHU zero-extends.
  - LW: full word.
- Ignored inputs:
  - mem_rvalid in IDLE, REQ or DONE.
  - start in any state other than IDLE, including the DONE cycle.
  - rs1_data, Iimm and funct3 after acceptance.

## Timing
- Reset values: mem_req=0, mem_addr=0, busy=0, done=0, load_data=0, load_err=0; state IDLE.
- Reset is asynchronous: mem_req and done drop the moment rst_n falls, even mid-transaction. A response arriving after reset is ignored.
- mem_req and mem_addr are registered. mem_req stays high until the cycle mem_ready is sampled high, inclusive.
- Best-case valid load: start at edge 0; REQ in cycle 1 with mem_ready=1; mem_rvalid in cycle 2; done plus data in cycle 3. Latency is 3 cycles from start to done.
- Each wait cycle on mem_ready or mem_rvalid adds exactly one cycle.
- Error load: start at edge 0, done=1 and load_err=1 in cycle 1, with load_data=0 and mem_req never asserted.
- mem_rvalid asserted in the same cycle as mem_ready is not accepted. The response counts only in WAIT, from the following cycle.
- Back-to-back: start is accepted again in the first IDLE cycle after DONE. Minimum spacing is 4 cycles for valid loads and 2 for error loads.
- load_err is cleared on the next done without an error.

## Test plan
- LB: rs1=0x1000, Iimm=3, mem_rdata=0x80123456 -> mem_addr=0x1000, load_data=0xFFFFFF80 at cycle 3. Repeat as LBU -> 0x00000080.
- LH: rs1=0x2000, Iimm=2, mem_rdata=0x80017FFF -> 0xFFFF8001. LHU with offset 0 on the same word -> 0x00007FFF.
- LW with backpressure: mem_ready low for 2 cycles, mem_rvalid 3 cycles after acceptance. Required: mem_req held for 3 cycles with mem_addr stable, done at cycle 7, load_data equal to mem_rdata. A stray mem_rvalid during REQ is ignored.
- Misaligned and illegal loads: LW to 0x1002, LH to 0x1001, funct3=011 -> each gives done and load_err in cycle 1, load_data=0, no mem_req.
- Reset mid-WAIT: rst_n low for 1 cycle, then mem_rvalid=1 -> all outputs at reset values, no done, state IDLE. A following LW completes normally.
- Start while busy: second start pulse during WAIT and during DONE -> ignored, exactly one done observed.

Source files
------------

// File: rtl/load_unit.sv
// Sequential load path: effective-address calculation, word-aligned memory read with
// request/ready handshake, then byte/halfword/word extraction with sign or zero extension.
module load_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] rs1_data,
  input  logic [31:0] Iimm,
  input  logic [2:0]  funct3,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        load_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [1:0]  r_off;
  logic [2:0]  r_f3;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic [31:0] r_data;
  logic        r_err;

  logic [31:0] w_eff;
  logic        w_bad;
  logic        w_accept;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  assign w_eff    = rs1_data + Iimm;
  assign w_accept = (r_state == S_IDLE) && start;

  // Illegal or misaligned loads never reach memory.
  always_comb begin
    w_bad = 1'b1;
    case (funct3)
      3'b000, 3'b100: w_bad = 1'b0;
      3'b001, 3'b101: w_bad = w_eff[0];
      3'b010:         w_bad = |w_eff[1:0];
      default:        w_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = w_bad ? S_DONE : S_REQ;
      S_REQ:  if (mem_ready) w_next = S_WAIT;
      S_WAIT: if (mem_rvalid) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  assign w_byte = mem_rdata[{r_off, 3'b000} +: 8];
  assign w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    w_ext = mem_rdata;
    case (r_f3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext = {24'b0, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'b0, w_half};
      default: w_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_off      <= 2'b00;
      r_f3       <= 3'b000;
      r_mem_req  <= 1'b0;
      r_mem_addr <= 32'h0;
      r_data     <= 32'h0;
      r_err      <= 1'b0;
    end else begin
      // Request stays up through the cycle mem_ready is seen high.
      r_mem_req <= (w_next == S_REQ);
      if (w_accept) begin
        r_off <= w_eff[1:0];
        r_f3  <= funct3;
        if (!w_bad) r_mem_addr <= {w_eff[31:2], 2'b00};
      end
      if (w_accept && w_bad) begin
        r_data <= 32'h0;
        r_err  <= 1'b1;
      end else if (r_state == S_WAIT && mem_rvalid) begin
        r_data <= w_ext;
        r_err  <= 1'b0;
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign load_data = r_data;
  assign load_err  = r_err;

endmodule

// File: tb/tb_load_unit.sv
// Bench for load_unit: directed vector table, hand-written reset/busy sequences and
// random loads checked against an arithmetic model of the load rules.
module tb_load_unit;

  logic        clk, rst_n, start;
  logic [31:0] rs1_data, Iimm;
  logic [2:0]  funct3;
  logic        mem_req, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_rdata;
  logic        busy, done, load_err;
  logic [31:0] load_data;

  int checks = 0;
  int errors = 0;

  load_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rs1_data(rs1_data), .Iimm(Iimm),
    .funct3(funct3), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy), .done(done),
    .load_data(load_data), .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [31:0] rdata;
    int          rdy_w;
    int          rv_w;
    bit          stray;
    logic [31:0] exp_data;
    bit          exp_err;
    string       nm;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference: load semantics from plain arithmetic on the effective address.
  function automatic void model(input logic [31:0] rs1, input logic [31:0] imm,
                                input logic [2:0] f3, input logic [31:0] rd,
                                output logic [31:0] d, output bit e);
    logic [31:0] eff;
    longint      v, w;
    int          off;
    eff = rs1 + imm;
    off = int'(eff[1:0]);
    w   = longint'({32'b0, rd});
    d = 32'h0;
    e = 1'b0;
    case (f3)
      3'd0, 3'd4: begin
        v = (w >> (8 * off)) % 256;
        if (f3 == 3'd0 && v >= 128) v = v - 256;
        d = v[31:0];
      end
      3'd1, 3'd5: begin
        if (off % 2 != 0) e = 1'b1;
        else begin
          v = (w >> ((off == 2) ? 16 : 0)) % 65536;
          if (f3 == 3'd1 && v >= 32768) v = v - 65536;
          d = v[31:0];
        end
      end
      3'd2: begin
        if (off != 0) e = 1'b1;
        else d = rd;
      end
      default: e = 1'b1;
    endcase
  endfunction

  // Called at a negedge in IDLE; returns at the negedge after done (IDLE again).
  task automatic do_load(input vec_t v);
    int          req_n, acc, dcyc;
    bit          seen;
    logic [31:0] eff, exp_addr;
    eff      = v.rs1 + v.imm;
    exp_addr = {eff[31:2], 2'b00};
    rs1_data = v.rs1; Iimm = v.imm; funct3 = v.f3; start = 1'b1;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    acc = -1; req_n = 0; seen = 1'b0; dcyc = 0;
    for (int cyc = 1; cyc <= 60 && !seen; cyc++) begin
      @(negedge clk);
      start = 1'b0; rs1_data = $urandom; Iimm = $urandom; funct3 = 3'($urandom);
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (done) begin
        seen = 1'b1; dcyc = cyc;
        chk({v.nm, " data"}, load_data, v.exp_data);
        chk({v.nm, " err"}, 32'(load_err), 32'(v.exp_err));
      end else if (mem_req) begin
        req_n++;
        chk({v.nm, " addr"}, mem_addr, exp_addr);
        if (req_n > v.rdy_w) begin mem_ready = 1'b1; acc = cyc; end
        if (v.stray) mem_rvalid = 1'b1;
      end else if (acc >= 0 && cyc == acc + 1 + v.rv_w) begin
        mem_rvalid = 1'b1; mem_rdata = v.rdata;
      end
    end
    if (!seen) chk({v.nm, " timeout"}, 32'd0, 32'd1);
    chk({v.nm, " latency"}, 32'(dcyc), v.exp_err ? 32'd1 : 32'(3 + v.rdy_w + v.rv_w));
    chk({v.nm, " req cycles"}, 32'(req_n), v.exp_err ? 32'd0 : 32'(v.rdy_w + 1));
    @(negedge clk);
    chk({v.nm, " done pulse"}, 32'(done), 32'd0);
    chk({v.nm, " idle"}, 32'(busy), 32'd0);
  endtask

  vec_t tbl[$];
  vec_t rv;

  initial begin
    int n_done, n_req;
    rst_n = 1'b0; start = 1'b0; rs1_data = 0; Iimm = 0; funct3 = 0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst mem_req", 32'(mem_req), 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst load_data", load_data, 0);
    chk("rst load_err", 32'(load_err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    tbl.push_back('{32'h1000, 32'd3, 3'b000, 32'h80123456, 0, 0, 0, 32'hFFFFFF80, 0, "LB"});
    tbl.push_back('{32'h1000, 32'd3, 3'b100, 32'h80123456, 0, 0, 0, 32'h00000080, 0, "LBU"});
    tbl.push_back('{32'h2000, 32'd2, 3'b001, 32'h80017FFF, 0, 0, 0, 32'hFFFF8001, 0, "LH"});
    tbl.push_back('{32'h2000, 32'd0, 3'b101, 32'h80017FFF, 0, 0, 0, 32'h00007FFF, 0, "LHU"});
    tbl.push_back('{32'h1000, 32'd0, 3'b010, 32'hDEADBEEF, 2, 2, 1, 32'hDEADBEEF, 0, "LW bp"});
    tbl.push_back('{32'h1000, 32'd2, 3'b010, 32'h0, 0, 0, 0, 32'h0, 1, "LW misal"});
    tbl.push_back('{32'h1000, 32'd1, 3'b001, 32'h0, 0, 0, 0, 32'h0, 1, "LH misal"});
    tbl.push_back('{32'h1000, 32'd0, 3'b011, 32'h0, 0, 0, 0, 32'h0, 1, "f3 011"});
    tbl.push_back('{32'h1001, 32'd0, 3'b101, 32'h0, 0, 0, 0, 32'h0, 1, "LHU misal"});
    tbl.push_back('{32'h1000, 32'd0, 3'b111, 32'h0, 0, 0, 0, 32'h0, 1, "f3 111"});
    tbl.push_back('{32'h10, 32'hFFFFFFF1, 3'b000, 32'h1234AB78, 1, 0, 0, 32'hFFFFFFAB, 0, "LB wrap"});
    tbl.push_back('{32'h3000, 32'd2, 3'b101, 32'hFFFF0000, 0, 1, 1, 32'h0000FFFF, 0, "LHU hi"});
    foreach (tbl[i]) do_load(tbl[i]);

    // Reset during WAIT, then a late response that must be ignored.
    start = 1'b1; rs1_data = 32'h4000; Iimm = 0; funct3 = 3'b010;
    @(negedge clk); start = 1'b0; mem_ready = mem_req;
    @(negedge clk); mem_ready = 1'b0;
    chk("rstw in wait", 32'(busy), 1);
    rst_n = 1'b0; #1;
    chk("rstw mem_req", 32'(mem_req), 0);
    chk("rstw done", 32'(done), 0);
    chk("rstw busy", 32'(busy), 0);
    chk("rstw load_data", load_data, 0);
    chk("rstw load_err", 32'(load_err), 0);
    @(negedge clk); rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
    n_done = 0;
    repeat (5) begin @(negedge clk); mem_rvalid = 1'b0; if (done) n_done++; end
    chk("rstw no done", 32'(n_done), 0);
    chk("rstw idle", 32'(busy), 0);
    do_load('{32'h4000, 32'd0, 3'b010, 32'hCAFEF00D, 0, 0, 0, 32'hCAFEF00D, 0, "LW after rst"});

    // Start pulses during WAIT and DONE must be ignored.
    start = 1'b1; rs1_data = 32'h5000; Iimm = 1; funct3 = 3'b100;
    n_done = 0; n_req = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      start = (cyc == 2 || cyc == 3);
      mem_ready = 1'b0; mem_rvalid = 1'b0;
      if (mem_req) begin n_req++; mem_ready = 1'b1; end
      if (cyc == 2) begin mem_rvalid = 1'b1; mem_rdata = 32'h0000C300; end
      if (done) n_done++;
    end
    start = 1'b0;
    chk("busy start dones", 32'(n_done), 1);
    chk("busy start reqs", 32'(n_req), 1);
    chk("busy start data", load_data, 32'h000000C3);

    // Random loads, back-to-back, against the model.
    for (int i = 0; i < 60; i++) begin
      rv.rs1   = (i % 2 == 0) ? $urandom : 32'h8000 + 32'($urandom_range(0, 7));
      rv.imm   = 32'($urandom_range(0, 15)) - 32'd8;
      rv.f3    = 3'($urandom_range(0, 7));
      rv.rdata = $urandom;
      rv.rdy_w = $urandom_range(0, 3);
      rv.rv_w  = $urandom_range(0, 3);
      rv.stray = 1'($urandom);
      rv.nm    = $sformatf("rnd%0d", i);
      model(rv.rs1, rv.imm, rv.f3, rv.rdata, rv.exp_data, rv.exp_err);
      do_load(rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
